// File: rtl/reset_seq_pkg.sv
// Shared definitions for the channel reset sequencer.
// - Channel state encoding (also exported in the status word).
// - Status word bit positions.
// - Legal channel-count check used at elaboration.
package reset_seq_pkg;

  localparam int unsigned MaxChannels = 8;

  // Channel FSM states; the two-bit value is reported as-is in sts.
  localparam logic [1:0] StOff  = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StRamp = 2'd2;
  localparam logic [1:0] StHalt = 2'd3;

  // Status word layout; channel i occupies bits [2i+1:2i].
  localparam int unsigned StsTrigBit  = 16;
  localparam int unsigned StsFaultBit = 17;
  localparam int unsigned StsAcqBit   = 18;
  localparam int unsigned StsWdBit    = 19;
  localparam int unsigned StsInstBit  = 20;

  function automatic bit num_channels_ok(int unsigned n);
    return (n >= 1) && (n <= MaxChannels);
  endfunction

endpackage

// File: rtl/channel_reset_fsm.sv
// Per-channel reset FSM with ramp-down handshake and ramp timeout.
// Ports:
//   clk, peripheral_reset  - clock and synchronous active-high reset
//   trigger_state          - shared registered trigger
//   channel_enable         - run permission for this channel
//   ramp_enable            - request a ramp-down before resetting the DAC
//   halt                   - instant-reset / watchdog halt event
//   ramp_done              - ramp-down complete (level)
//   state                  - current state, for the status word
//   dac_aresetn            - active-low DAC reset (released in RUN and RAMP)
//   start_ramp_down        - ramp request (RAMP only)
module channel_reset_fsm
  import reset_seq_pkg::*;
#(
  parameter int unsigned RAMP_TIMEOUT_CYCLES = 125000,
  parameter int unsigned CNT_WIDTH           = 28
) (
  input  logic       clk,
  input  logic       peripheral_reset,
  input  logic       trigger_state,
  input  logic       channel_enable,
  input  logic       ramp_enable,
  input  logic       halt,
  input  logic       ramp_done,
  output logic [1:0] state,
  output logic       dac_aresetn,
  output logic       start_ramp_down
);

  localparam logic [CNT_WIDTH-1:0] RampLimit = CNT_WIDTH'(RAMP_TIMEOUT_CYCLES - 1);

  logic [1:0]           state_d, state_q;
  logic [CNT_WIDTH-1:0] timer_d, timer_q;
  logic                 halt_seen_d, halt_seen_q;
  logic                 stop;

  always_comb begin
    stop        = !trigger_state || !channel_enable || halt;
    state_d     = state_q;
    timer_d     = timer_q;
    halt_seen_d = halt_seen_q;
    case (state_q)
      StOff: begin
        if (trigger_state && channel_enable && !halt) state_d = StRun;
      end
      StRun: begin
        // Timer and halt memory are primed here so RAMP always starts clean.
        timer_d     = '0;
        halt_seen_d = halt;
        if (stop) begin
          if (ramp_enable) state_d = StRamp;
          else             state_d = halt ? StHalt : StOff;
        end
      end
      StRamp: begin
        halt_seen_d = halt_seen_q | halt;
        if (timer_q != RampLimit) timer_d = timer_q + CNT_WIDTH'(1);
        if (ramp_done || (timer_q == RampLimit)) begin
          state_d = halt_seen_d ? StHalt : StOff;
        end
      end
      StHalt: begin
        // Re-arm only once the trigger has dropped and the halt cause is gone.
        if (!trigger_state && !halt) state_d = StOff;
      end
      default: state_d = StOff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (peripheral_reset) begin
      state_q     <= StOff;
      timer_q     <= '0;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  assign state           = state_q;
  assign dac_aresetn     = (state_q == StRun) || (state_q == StRamp);
  assign start_ramp_down = (state_q == StRamp);

endmodule

// File: rtl/channel_reset_sequencer.sv
// Reset/trigger manager for NUM_CHANNELS DAC channels.
// Synchronises ext_trigger/watchdog/instant_reset, derives the shared trigger state,
// releases acquisition and per-channel DAC resets, supervises the watchdog, produces
// the alive heartbeat and packs a 32-bit status word.
// Ports: clk/peripheral_reset (sync, active-high); cfg_* configuration; async pins
// ext_trigger, watchdog, instant_reset; counter_trigger (clk domain); ramp_done per
// channel; outputs acq_aresetn, dac_aresetn, start_ramp_down, fault, alive_signal, sts.
module channel_reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS            = 2,
  parameter int unsigned ALIVE_LOW_CYCLES        = 12500000,
  parameter int unsigned ALIVE_HIGH_CYCLES       = 1250000,
  parameter int unsigned WATCHDOG_TIMEOUT_CYCLES = 12500000,
  parameter int unsigned RAMP_TIMEOUT_CYCLES     = 125000,
  parameter int unsigned CNT_WIDTH               = 28
) (
  input  logic                    clk,
  input  logic                    peripheral_reset,
  input  logic                    cfg_trigger_mode,
  input  logic                    cfg_external_trigger,
  input  logic                    cfg_internal_trigger_enable,
  input  logic                    cfg_watchdog_enable,
  input  logic                    cfg_instant_reset_enable,
  input  logic [NUM_CHANNELS-1:0] cfg_channel_enable,
  input  logic [NUM_CHANNELS-1:0] cfg_ramp_enable,
  input  logic                    ext_trigger,
  input  logic                    watchdog,
  input  logic                    instant_reset,
  input  logic                    counter_trigger,
  input  logic [NUM_CHANNELS-1:0] ramp_done,
  output logic                    acq_aresetn,
  output logic [NUM_CHANNELS-1:0] dac_aresetn,
  output logic [NUM_CHANNELS-1:0] start_ramp_down,
  output logic                    fault,
  output logic                    alive_signal,
  output logic [31:0]             sts
);

  if (!num_channels_ok(NUM_CHANNELS)) begin : g_bad_channels
    $error("NUM_CHANNELS must be in 1..8");
  end

  localparam logic [CNT_WIDTH-1:0] WdLimit   = CNT_WIDTH'(WATCHDOG_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] AliveWrap =
      CNT_WIDTH'(ALIVE_LOW_CYCLES + ALIVE_HIGH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] AliveLow  = CNT_WIDTH'(ALIVE_LOW_CYCLES);

  // Synchroniser bit order: {instant_reset, watchdog, ext_trigger}.
  logic [2:0]           sync1_q, sync2_q;
  logic                 wd_prev_q;
  logic                 ext_sync, wd_sync, inst_sync;
  logic                 trigger_state_d, trigger_state_q;
  logic                 acq_q;
  logic [CNT_WIDTH-1:0] wd_cnt_d, wd_cnt_q;
  logic                 fault_d, fault_q;
  logic [CNT_WIDTH-1:0] alive_cnt_d, alive_cnt_q;
  logic                 alive_d, alive_q;
  logic                 wd_active, wd_edge, halt;

  logic [NUM_CHANNELS-1:0][1:0] ch_state;

  assign ext_sync  = sync2_q[0];
  assign wd_sync   = sync2_q[1];
  assign inst_sync = sync2_q[2];

  assign halt      = (cfg_instant_reset_enable & inst_sync) | fault_q;
  assign wd_active = cfg_watchdog_enable & trigger_state_q;
  assign wd_edge   = wd_sync ^ wd_prev_q;

  always_comb begin
    if (!cfg_trigger_mode)         trigger_state_d = 1'b1;
    else if (cfg_external_trigger) trigger_state_d = ext_sync;
    else                           trigger_state_d = counter_trigger & cfg_internal_trigger_enable;

    wd_cnt_d = wd_cnt_q;
    fault_d  = fault_q;
    if (!wd_active) begin
      wd_cnt_d = '0;
      fault_d  = 1'b0;
    end else begin
      if (wd_edge)                wd_cnt_d = '0;
      else if (wd_cnt_q != WdLimit) wd_cnt_d = wd_cnt_q + CNT_WIDTH'(1);
      if (wd_cnt_q == WdLimit)    fault_d  = 1'b1;
    end

    alive_cnt_d = (alive_cnt_q == AliveWrap) ? '0 : alive_cnt_q + CNT_WIDTH'(1);
    alive_d     = (alive_cnt_q >= AliveLow);
  end

  always_ff @(posedge clk) begin
    if (peripheral_reset) begin
      sync1_q         <= '0;
      sync2_q         <= '0;
      wd_prev_q       <= 1'b0;
      trigger_state_q <= 1'b0;
      acq_q           <= 1'b0;
      wd_cnt_q        <= '0;
      fault_q         <= 1'b0;
      alive_cnt_q     <= '0;
      alive_q         <= 1'b0;
    end else begin
      sync1_q         <= {instant_reset, watchdog, ext_trigger};
      sync2_q         <= sync1_q;
      wd_prev_q       <= wd_sync;
      trigger_state_q <= trigger_state_d;
      acq_q           <= trigger_state_q;
      wd_cnt_q        <= wd_cnt_d;
      fault_q         <= fault_d;
      alive_cnt_q     <= alive_cnt_d;
      alive_q         <= alive_d;
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    channel_reset_fsm #(
      .RAMP_TIMEOUT_CYCLES(RAMP_TIMEOUT_CYCLES),
      .CNT_WIDTH          (CNT_WIDTH)
    ) u_fsm (
      .clk             (clk),
      .peripheral_reset(peripheral_reset),
      .trigger_state   (trigger_state_q),
      .channel_enable  (cfg_channel_enable[i]),
      .ramp_enable     (cfg_ramp_enable[i]),
      .halt            (halt),
      .ramp_done       (ramp_done[i]),
      .state           (ch_state[i]),
      .dac_aresetn     (dac_aresetn[i]),
      .start_ramp_down (start_ramp_down[i])
    );
  end

  always_comb begin
    sts = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) sts[2*i +: 2] = ch_state[i];
    sts[StsTrigBit]  = trigger_state_q;
    sts[StsFaultBit] = fault_q;
    sts[StsAcqBit]   = acq_q;
    sts[StsWdBit]    = wd_sync;
    sts[StsInstBit]  = inst_sync;
  end

  assign acq_aresetn  = acq_q;
  assign fault        = fault_q;
  assign alive_signal = alive_q;

endmodule

// File: tb/tb_channel_reset_sequencer.sv
// Self-checking bench for channel_reset_sequencer (2 channels, ramp 20, watchdog 50,
// alive 10/5).
module tb_channel_reset_sequencer;

  logic       clk = 1'b0;
  logic       peripheral_reset;
  logic       cfg_trigger_mode, cfg_external_trigger, cfg_internal_trigger_enable;
  logic       cfg_watchdog_enable, cfg_instant_reset_enable;
  logic [1:0] cfg_channel_enable, cfg_ramp_enable;
  logic       ext_trigger, watchdog, instant_reset, counter_trigger;
  logic [1:0] ramp_done;
  logic       acq_aresetn, fault, alive_signal;
  logic [1:0] dac_aresetn, start_ramp_down;
  logic [31:0] sts;

  channel_reset_sequencer #(
    .NUM_CHANNELS           (2),
    .ALIVE_LOW_CYCLES       (10),
    .ALIVE_HIGH_CYCLES      (5),
    .WATCHDOG_TIMEOUT_CYCLES(50),
    .RAMP_TIMEOUT_CYCLES    (20),
    .CNT_WIDTH              (28)
  ) dut (
    .clk                        (clk),
    .peripheral_reset           (peripheral_reset),
    .cfg_trigger_mode           (cfg_trigger_mode),
    .cfg_external_trigger       (cfg_external_trigger),
    .cfg_internal_trigger_enable(cfg_internal_trigger_enable),
    .cfg_watchdog_enable        (cfg_watchdog_enable),
    .cfg_instant_reset_enable   (cfg_instant_reset_enable),
    .cfg_channel_enable         (cfg_channel_enable),
    .cfg_ramp_enable            (cfg_ramp_enable),
    .ext_trigger                (ext_trigger),
    .watchdog                   (watchdog),
    .instant_reset              (instant_reset),
    .counter_trigger            (counter_trigger),
    .ramp_done                  (ramp_done),
    .acq_aresetn                (acq_aresetn),
    .dac_aresetn                (dac_aresetn),
    .start_ramp_down            (start_ramp_down),
    .fault                      (fault),
    .alive_signal               (alive_signal),
    .sts                        (sts)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        acq;
    logic [1:0]  dac;
    logic [1:0]  srd;
    logic        flt;
    logic [31:0] sts;
  } exp_t;

  typedef struct {
    logic        trig_mode;
    logic        int_en;
    logic        ctr;
    logic [1:0]  ch_en;
    int          wait_cyc;
    logic        acq;
    logic [1:0]  dac;
    logic [31:0] sts;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Leaves the caller 1 time unit after a rising edge: safe to sample and drive.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow: queue empty, required one entry");
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (acq_aresetn !== e.acq || dac_aresetn !== e.dac || start_ramp_down !== e.srd ||
        fault !== e.flt || sts !== e.sts) begin
      errors++;
      $display("FAIL %s: got acq=%b dac=%b srd=%b fault=%b sts=%h, want acq=%b dac=%b srd=%b fault=%b sts=%h",
               e.name, acq_aresetn, dac_aresetn, start_ramp_down, fault, sts,
               e.acq, e.dac, e.srd, e.flt, e.sts);
    end
  endtask

  task automatic expect_after(input int n, input string name, input logic acq,
                              input logic [1:0] dac, input logic [1:0] srd,
                              input logic flt, input logic [31:0] s);
    exp_t e;
    e.name = name; e.acq = acq; e.dac = dac; e.srd = srd; e.flt = flt; e.sts = s;
    sb_q.push_back(e);
    tick(n);
    pop_check();
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  vec_t vecs[10];
  logic alive_hist[45];

  initial begin
    // Internal-trigger / continuous-mode table: inputs then expected outputs.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 2'b11, 1, 1'b0, 2'b00, 32'h0001_0000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 2'b11, 1, 1'b1, 2'b11, 32'h0005_0005};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 2'b01, 1, 1'b1, 2'b01, 32'h0005_0001};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 2'b11, 1, 1'b1, 2'b11, 32'h0005_0005};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 2'b11, 1, 1'b1, 2'b11, 32'h0004_0005};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2'b11, 1, 1'b0, 2'b00, 32'h0000_0000};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 2'b11, 2, 1'b1, 2'b11, 32'h0005_0005};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 2'b11, 2, 1'b0, 2'b00, 32'h0000_0000};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 2'b11, 2, 1'b1, 2'b11, 32'h0005_0005};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 2'b11, 2, 1'b0, 2'b00, 32'h0000_0000};

    peripheral_reset = 1'b1;
    cfg_trigger_mode = 1'b1; cfg_external_trigger = 1'b0; cfg_internal_trigger_enable = 1'b0;
    cfg_watchdog_enable = 1'b0; cfg_instant_reset_enable = 1'b0;
    cfg_channel_enable = 2'b11; cfg_ramp_enable = 2'b00;
    ext_trigger = 1'b0; watchdog = 1'b0; instant_reset = 1'b0; counter_trigger = 1'b0;
    ramp_done = 2'b00;

    // Reset state.
    expect_after(4, "reset_state", 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
    check_val("reset_alive", int'(alive_signal), 0);
    peripheral_reset = 1'b0;
    tick(2);

    // Table-driven internal trigger / channel enable / continuous mode.
    for (int i = 0; i < 10; i++) begin
      cfg_trigger_mode            = vecs[i].trig_mode;
      cfg_internal_trigger_enable = vecs[i].int_en;
      counter_trigger             = vecs[i].ctr;
      cfg_channel_enable          = vecs[i].ch_en;
      expect_after(vecs[i].wait_cyc, $sformatf("vec%0d", i), vecs[i].acq, vecs[i].dac,
                   2'b00, 1'b0, vecs[i].sts);
    end

    // External trigger with ramp-down on both channels.
    cfg_external_trigger = 1'b1; cfg_ramp_enable = 2'b11;
    ext_trigger = 1'b1;
    expect_after(3, "ext_trig_state", 1'b0, 2'b00, 2'b00, 1'b0, 32'h0001_0000);
    expect_after(1, "ext_release",    1'b1, 2'b11, 2'b00, 1'b0, 32'h0005_0005);
    ext_trigger = 1'b0;
    expect_after(3, "ext_fall_run",   1'b1, 2'b11, 2'b00, 1'b0, 32'h0004_0005);
    expect_after(1, "ramp_entry",     1'b0, 2'b11, 2'b11, 1'b0, 32'h0000_000A);
    tick(5);
    ramp_done = 2'b01;
    expect_after(1, "ramp_done0",     1'b0, 2'b10, 2'b10, 1'b0, 32'h0000_0008);
    ramp_done = 2'b00;
    expect_after(13, "ch1_pre_timeout", 1'b0, 2'b10, 2'b10, 1'b0, 32'h0000_0008);
    expect_after(1, "ch1_timeout",    1'b0, 2'b00, 2'b00, 1'b0, 32'h0);

    // Instant reset with ramp disabled: straight to HALT, re-arm after trigger drop.
    cfg_ramp_enable = 2'b00; cfg_instant_reset_enable = 1'b1;
    ext_trigger = 1'b1;
    expect_after(4, "inst_run",       1'b1, 2'b11, 2'b00, 1'b0, 32'h0005_0005);
    instant_reset = 1'b1;
    tick(1);
    instant_reset = 1'b0;
    expect_after(1, "inst_sync",      1'b1, 2'b11, 2'b00, 1'b0, 32'h0015_0005);
    expect_after(1, "inst_halt",      1'b1, 2'b00, 2'b00, 1'b0, 32'h0005_000F);
    expect_after(5, "inst_halt_hold", 1'b1, 2'b00, 2'b00, 1'b0, 32'h0005_000F);
    ext_trigger = 1'b0;
    expect_after(3, "inst_trig_low",  1'b1, 2'b00, 2'b00, 1'b0, 32'h0004_000F);
    expect_after(1, "inst_rearm",     1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
    cfg_instant_reset_enable = 1'b0;

    // Watchdog timeout: fault, halt through ramp, clear once trigger drops.
    cfg_watchdog_enable = 1'b1; cfg_ramp_enable = 2'b11;
    ext_trigger = 1'b1;
    expect_after(4, "wd_run",         1'b1, 2'b11, 2'b00, 1'b0, 32'h0005_0005);
    expect_after(48, "wd_pre_fault",  1'b1, 2'b11, 2'b00, 1'b0, 32'h0005_0005);
    expect_after(1, "wd_fault",       1'b1, 2'b11, 2'b00, 1'b1, 32'h0007_0005);
    expect_after(1, "wd_ramp",        1'b1, 2'b11, 2'b11, 1'b1, 32'h0007_000A);
    ramp_done = 2'b11;
    expect_after(1, "wd_halt",        1'b1, 2'b00, 2'b00, 1'b1, 32'h0007_000F);
    ramp_done = 2'b00;
    ext_trigger = 1'b0;
    expect_after(3, "wd_trig_low",    1'b1, 2'b00, 2'b00, 1'b1, 32'h0006_000F);
    expect_after(1, "wd_fault_clear", 1'b0, 2'b00, 2'b00, 1'b0, 32'h0000_000F);
    expect_after(1, "wd_rearm",       1'b0, 2'b00, 2'b00, 1'b0, 32'h0);

    // Watchdog fed every 40 cycles: no fault.
    begin
      int fault_seen = 0;
      ext_trigger = 1'b1;
      for (int k = 0; k < 4; k++) begin
        watchdog = ~watchdog;
        for (int j = 0; j < 40; j++) begin
          tick(1);
          if (fault === 1'b1) fault_seen++;
        end
      end
      check_val("wd_fed_no_fault", fault_seen, 0);
    end
    expect_after(1, "wd_fed_run",     1'b1, 2'b11, 2'b00, 1'b0, 32'h0005_0005);
    cfg_ramp_enable = 2'b00; cfg_watchdog_enable = 1'b0;
    ext_trigger = 1'b0;
    expect_after(4, "wd_fed_off",     1'b0, 2'b00, 2'b00, 1'b0, 32'h0);

    // ramp_done and timeout on the same cycle with a halt seen during RAMP.
    cfg_ramp_enable = 2'b11; cfg_instant_reset_enable = 1'b1;
    ext_trigger = 1'b1;
    expect_after(4, "dual_run",       1'b1, 2'b11, 2'b00, 1'b0, 32'h0005_0005);
    cfg_channel_enable = 2'b00;
    expect_after(1, "dual_ramp",      1'b1, 2'b11, 2'b11, 1'b0, 32'h0005_000A);
    tick(1);
    instant_reset = 1'b1;
    tick(1);
    instant_reset = 1'b0;
    tick(17);
    ramp_done = 2'b11;
    expect_after(1, "dual_halt",      1'b1, 2'b00, 2'b00, 1'b0, 32'h0005_000F);
    ramp_done = 2'b00; cfg_channel_enable = 2'b11;
    expect_after(3, "dual_halt_hold", 1'b1, 2'b00, 2'b00, 1'b0, 32'h0005_000F);
    ext_trigger = 1'b0;
    expect_after(3, "dual_trig_low",  1'b1, 2'b00, 2'b00, 1'b0, 32'h0004_000F);
    expect_after(1, "dual_rearm",     1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
    cfg_instant_reset_enable = 1'b0;

    // peripheral_reset in RAMP, then continuous mode after release.
    ext_trigger = 1'b1;
    expect_after(4, "rst_run",        1'b1, 2'b11, 2'b00, 1'b0, 32'h0005_0005);
    ext_trigger = 1'b0;
    expect_after(4, "rst_ramp",       1'b0, 2'b11, 2'b11, 1'b0, 32'h0000_000A);
    peripheral_reset = 1'b1; cfg_trigger_mode = 1'b0;
    expect_after(1, "rst_in_ramp",    1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
    check_val("rst_alive", int'(alive_signal), 0);
    tick(2);
    peripheral_reset = 1'b0;
    expect_after(1, "cont_plus1",     1'b0, 2'b00, 2'b00, 1'b0, 32'h0001_0000);
    expect_after(1, "cont_plus2",     1'b1, 2'b11, 2'b00, 1'b0, 32'h0005_0005);
    tick(8);
    check_val("alive_low_edge10", int'(alive_signal), 0);
    tick(1);
    check_val("alive_high_edge11", int'(alive_signal), 1);

    // Alive heartbeat over three periods.
    begin
      int highs = 0, bad_period = 0, run = 0, max_run = 0;
      for (int i = 0; i < 45; i++) begin
        tick(1);
        alive_hist[i] = alive_signal;
        if (alive_signal === 1'b1) begin
          highs++;
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
        if (i >= 15 && alive_hist[i] !== alive_hist[i-15]) bad_period++;
      end
      check_val("alive_high_count", highs, 15);
      check_val("alive_period", bad_period, 0);
      check_val("alive_high_run", max_run, 5);
    end

    cfg_ramp_enable = 2'b00; cfg_trigger_mode = 1'b1;
    expect_after(4, "final_off",      1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
    check_val("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
